rho_inv_iter: RTL



---
 rtl/rho_pkg.sv | 15 +
 rtl/rotr_lane.sv | 10 +
 rtl/rho_inv_iter.sv | 56 +++++
 3 files changed

// File: rtl/rho_pkg.sv
// rho_pkg: rho offsets, lane indexing and FSM encoding shared by the inverse-rho block.
package rho_pkg;
  localparam int NLANES = 25;
  localparam logic [5:0] RHO_OFFSET [0:24] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction
endpackage

// File: rtl/rotr_lane.sv
// rotr_lane: combinational right rotation of one lane.
module rotr_lane #(
  parameter int W = 64
) (
  input  logic [W-1:0]         lane,
  input  logic [$clog2(W)-1:0] amount,
  output logic [W-1:0]         rot
);
  assign rot = (lane >> amount) | (lane << (W - int'(amount)));
endmodule

// File: rtl/rho_inv_iter.sv
// rho_inv_iter: iterative inverse rho, one lane rotated right per clock through a shared rotator.
module rho_inv_iter
  import rho_pkg::*;
#(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25*W-1:0]   in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [25*W-1:0]   out_state
);
  localparam int AW = $clog2(W);
  state_t st_q, st_d;
  logic [4:0] cnt_q, cnt_d;
  logic [25*W-1:0] state_q, state_d;
  logic [W-1:0] lane, rot;
  logic [AW-1:0] amount;
  assign lane = state_q[cnt_q*W +: W];
  // W is a power of two, so the low offset bits are the offset mod W
  assign amount = RHO_OFFSET[cnt_q][AW-1:0];
  rotr_lane #(.W(W)) u_rot (.lane(lane), .amount(amount), .rot(rot));
  assign in_ready = (st_q == IDLE) && !rst;
  assign out_valid = (st_q == DONE);
  assign out_state = state_q;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    state_d = state_q;
    if (st_q == IDLE && in_valid) begin
      state_d = in_state;
      cnt_d = '0;
      st_d = RUN;
    end else if (st_q == RUN) begin
      state_d[cnt_q*W +: W] = rot;
      cnt_d = cnt_q + 5'd1;
      st_d = (cnt_q == 5'(NLANES - 1)) ? DONE : RUN;
    end else if (st_q == DONE && out_ready) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      state_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
endmodule
